// File: rtl/dmem_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_sb_pkg                                               |
// | Purpose  : Shared types and constants for the data-memory store      |
// |            buffer: entry layout, byte-enable width, byte merge.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dmem_sb_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int BE_WIDTH      = SB_DATA_WIDTH / 8;
  localparam int WADDR_WIDTH   = SB_ADDR_WIDTH - 2;

  // One buffered store; the address is kept as a word address.
  typedef struct packed {
    logic                     valid;
    logic [WADDR_WIDTH-1:0]   waddr;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]      be;
  } sb_entry_t;

  // Overlay the enabled byte lanes of new_data onto old_data.
  function automatic logic [SB_DATA_WIDTH-1:0] sb_merge_bytes(
    input logic [SB_DATA_WIDTH-1:0] old_data,
    input logic [SB_DATA_WIDTH-1:0] new_data,
    input logic [BE_WIDTH-1:0]      be
  );
    logic [SB_DATA_WIDTH-1:0] res;
    res = old_data;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sb_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_sb_match                                             |
// | Purpose  : Parallel word-address comparator across all buffer        |
// |            entries; returns one hit bit per valid matching entry.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_sb_match #(
  parameter int DEPTH    = 4,
  parameter int WA_WIDTH = 30
) (
  input  logic [WA_WIDTH-1:0]            addr_i,
  input  logic [DEPTH-1:0]               valid_i,
  input  logic [DEPTH-1:0][WA_WIDTH-1:0] waddr_i,
  output logic [DEPTH-1:0]               hit_o
);

  // Empty slots never match, so callers can treat hit_o as "occupied and equal".
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit_o[i] = valid_i[i] && (waddr_i[i] == addr_i);
  end

endmodule
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_store_buffer                                         |
// | Purpose  : Posted-write FIFO between the CPU data port and data      |
// |            memory. Stores retire in one cycle and drain when the     |
// |            shared address port is idle; loads win the port, and a    |
// |            load hitting a buffered word stalls until it drains.      |
// | Options  : DMEM_SB_COALESCE_EN - merge a store into the youngest     |
// |            entry when both target the same word.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_store_buffer
  import dmem_sb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  input  logic [BE_WIDTH-1:0]   cpu_wr_be,
  input  logic                  cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic                  sb_stall,
  output logic                  sb_empty,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be,
  input  logic                  mem_ready
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam int                WA_W     = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  sb_entry_t              entries_q [DEPTH];
  sb_entry_t              entries_d [DEPTH];
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [DEPTH-1:0]            valid_vec;
  logic [DEPTH-1:0][WA_W-1:0]  waddr_vec;
  logic [DEPTH-1:0]            ld_hit;

  logic buf_empty, buf_full;
  logic rd_req, hazard, load_pass, drain, pop, push;
  logic young_match, merge;
  logic unused_wr_lsb;

  // Store byte offset is implied by the byte enables; only the word is kept.
  assign unused_wr_lsb = ^cpu_wr_addr[1:0];

  // Present entry valid bits and word addresses to the comparators.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      waddr_vec[i] = entries_q[i].waddr;
    end
  end

  dmem_sb_match #(
    .DEPTH    (DEPTH),
    .WA_WIDTH (WA_W)
  ) u_ld_match (
    .addr_i  (cpu_rd_addr[ADDR_WIDTH-1:2]),
    .valid_i (valid_vec),
    .waddr_i (waddr_vec),
    .hit_o   (ld_hit)
  );

  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == FULL_CNT);

  // A concurrent store wins over a load, so the load is ignored then.
  assign rd_req    = cpu_rd_en && !cpu_wr_en;
  assign hazard    = rd_req && (|ld_hit);
  assign load_pass = rd_req && !hazard;
  assign drain     = !buf_empty && !load_pass;
  assign pop       = drain && mem_ready;

`ifdef DMEM_SB_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  logic [DEPTH-1:0] st_hit;

  assign youngest = tail_q - PTR_ONE;

  dmem_sb_match #(
    .DEPTH    (DEPTH),
    .WA_WIDTH (WA_W)
  ) u_st_match (
    .addr_i  (cpu_wr_addr[ADDR_WIDTH-1:2]),
    .valid_i (valid_vec),
    .waddr_i (waddr_vec),
    .hit_o   (st_hit)
  );

  // Youngest cannot be the head when full (DEPTH >= 2), so the stall
  // decision below stays independent of mem_ready.
  assign young_match = st_hit[youngest];
  assign merge       = cpu_wr_en && young_match && !(pop && (head_q == youngest));
`else
  assign young_match = 1'b0;
  assign merge       = 1'b0;
`endif

  // Full check uses the pre-pop count so stall never waits on mem_ready.
  assign push     = cpu_wr_en && !merge && !buf_full;
  assign sb_stall = hazard || (cpu_wr_en && buf_full && !young_match);

  // Next-state for FIFO contents, pointers and occupancy.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d                  = head_q + PTR_ONE;
    end
    if (push) begin
      entries_d[tail_q].valid = 1'b1;
      entries_d[tail_q].waddr = cpu_wr_addr[ADDR_WIDTH-1:2];
      entries_d[tail_q].data  = cpu_wr_data;
      entries_d[tail_q].be    = cpu_wr_be;
      tail_d                  = tail_q + PTR_ONE;
    end
`ifdef DMEM_SB_COALESCE_EN
    if (merge) begin
      entries_d[youngest].data = sb_merge_bytes(entries_q[youngest].data,
                                                cpu_wr_data, cpu_wr_be);
      entries_d[youngest].be   = entries_q[youngest].be | cpu_wr_be;
    end
`endif
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Shared memory port: a passing load owns it, otherwise the head drains.
  always_comb begin
    mem_rd_en   = load_pass;
    mem_wr_en   = drain;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_be   = '0;
    if (load_pass) begin
      mem_addr = cpu_rd_addr;
    end else if (drain) begin
      mem_addr    = {entries_q[head_q].waddr, 2'b00};
      mem_wr_data = entries_q[head_q].data;
      mem_wr_be   = entries_q[head_q].be;
    end
  end

  assign sb_empty = buf_empty;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_store_buffer                                      |
// | Purpose  : Scoreboard bench for dmem_store_buffer: a queue model of  |
// |            pending stores predicts port behaviour; a monitor checks  |
// |            each accepted memory write against the queue head.        |
// | Options  : DMEM_SB_COALESCE_EN - model merges into youngest store.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;

  logic          clk, rst;
  logic          cpu_wr_en, cpu_rd_en, mem_ready;
  logic [AW-1:0] cpu_wr_addr, cpu_rd_addr;
  logic [DW-1:0] cpu_wr_data;
  logic [BW-1:0] cpu_wr_be;
  logic          sb_stall, sb_empty, mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [BW-1:0] mem_wr_be;

  typedef struct {
    logic [AW-3:0] waddr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } st_t;

  st_t exp_q[$];
  st_t mon_e;
  int  checks   = 0;
  int  errors   = 0;
  int  n_writes = 0;

  dmem_store_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_addr (cpu_wr_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_wr_be   (cpu_wr_be),
    .cpu_rd_en   (cpu_rd_en),
    .cpu_rd_addr (cpu_rd_addr),
    .sb_stall    (sb_stall),
    .sb_empty    (sb_empty),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_be   (mem_wr_be),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Store and load are never issued together by a well-behaved CPU.
  always @(posedge clk) begin
    if (rst === 1'b1) assert (!(cpu_wr_en && cpu_rd_en)) else $error("store and load issued together");
  end

  // Monitor: every write the memory accepts must be the oldest modelled store.
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL drain_unexpected: got write to %0h expected no write at %0t", mem_addr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", 64'(mem_addr),    64'({mon_e.waddr, 2'b00}));
        chk("drain_data", 64'(mem_wr_data), 64'(mon_e.data));
        chk("drain_be",   64'(mem_wr_be),   64'(mon_e.be));
      end
    end
  end

  task automatic drive_idle();
    cpu_wr_en   = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    cpu_wr_be   = '0;
    cpu_rd_en   = 1'b0;
    cpu_rd_addr = '0;
  endtask

  // Reset for one cycle, checking the reset values while it is held.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    mem_ready = 1'b0;
    #2;
    chk("rst_sb_stall",    64'(sb_stall),    64'd0);
    chk("rst_sb_empty",    64'(sb_empty),    64'd1);
    chk("rst_mem_wr_en",   64'(mem_wr_en),   64'd0);
    chk("rst_mem_rd_en",   64'(mem_rd_en),   64'd0);
    chk("rst_mem_addr",    64'(mem_addr),    64'd0);
    chk("rst_mem_wr_data", 64'(mem_wr_data), 64'd0);
    chk("rst_mem_wr_be",   64'(mem_wr_be),   64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock of stimulus: drive, check port behaviour predicted from the
  // pending-store queue, then (after the monitor's pop) update the queue.
  task automatic cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [BW-1:0] wb, input logic rd, input logic [AW-1:0] ra,
                       input logic rdy);
    int            sz;
    logic          ld, haz, lp, drn, pop, ymatch, merge, push;
    logic [AW-1:0] eaddr;
    st_t           b;
    @(posedge clk); #1;
    cpu_wr_en   = wr;
    cpu_wr_addr = wa;
    cpu_wr_data = wd;
    cpu_wr_be   = wb;
    cpu_rd_en   = rd;
    cpu_rd_addr = ra;
    mem_ready   = rdy;
    #2;
    sz  = exp_q.size();
    ld  = rd && !wr;
    haz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].waddr == ra[AW-1:2]) haz = 1'b1;
    haz    = haz && ld;
    lp     = ld && !haz;
    drn    = (sz > 0) && !lp;
    pop    = drn && rdy;
    ymatch = 1'b0;
`ifdef DMEM_SB_COALESCE_EN
    if (sz > 0) ymatch = (exp_q[sz-1].waddr == wa[AW-1:2]);
`endif
    merge = wr && ymatch && !(pop && sz == 1);
    push  = wr && !merge && (sz < DEPTH);
    eaddr = lp ? ra : ((sz > 0) ? {exp_q[0].waddr, 2'b00} : '0);
    chk("sb_stall",  64'(sb_stall),  64'(haz || (wr && sz == DEPTH && !ymatch)));
    chk("sb_empty",  64'(sb_empty),  64'(sz == 0));
    chk("mem_wr_en", 64'(mem_wr_en), 64'(drn));
    chk("mem_rd_en", 64'(mem_rd_en), 64'(lp));
    chk("mem_addr",  64'(mem_addr),  64'(eaddr));
    #4;
    if (merge) begin
      b = exp_q[exp_q.size()-1];
      for (int k = 0; k < BW; k++) if (wb[k]) b.data[8*k +: 8] = wd[8*k +: 8];
      b.be = b.be | wb;
      exp_q[exp_q.size()-1] = b;
    end else if (push) begin
      b.waddr = wa[AW-1:2];
      b.data  = wd;
      b.be    = wb;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int w0;
    logic          r_wr, r_rd;
    logic [AW-1:0] r_wa, r_ra;

    rst = 1'b0;
    drive_idle();
    mem_ready = 1'b0;
    do_reset();

    // Fill to full with memory stalled, then release memory.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h1000_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h1000_0010, 32'h5555_AAAA, 4'hF, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h1000_0010, 32'h5555_AAAA, 4'hF, 1'b0, '0, 1'b1);
    cycle(1'b1, 32'h1000_0010, 32'h5555_AAAA, 4'hF, 1'b0, '0, 1'b1);
    idle(6, 1'b1);

    // Load hazard on a buffered word, cleared once it drains.
    cycle(1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h1000_0012, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h1000_0012, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h1000_0012, 1'b1);

    // Load priority over a pending drain.
    cycle(1'b1, 32'h1000_0040, 32'h0102_0304, 4'hF, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h1000_0044, 32'h0506_0708, 4'h3, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 32'h1000_0100, 1'b1);
    idle(3, 1'b1);

    // Wrap-around: back-to-back store/drain pairs.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h1000_0200 + 32'(4*i), $urandom, 4'(1 + i % 15), 1'b0, '0, 1'b1);
    idle(2, 1'b1);

    // Byte stores to the same word.
    w0 = n_writes;
    cycle(1'b1, 32'h1000_0020, 32'h0000_0011, 4'b0001, 1'b0, '0, 1'b0);
    cycle(1'b1, 32'h1000_0021, 32'h0000_2200, 4'b0010, 1'b0, '0, 1'b0);
    idle(4, 1'b1);
`ifdef DMEM_SB_COALESCE_EN
    chk("coalesce_writes", 64'(n_writes - w0), 64'd1);
`else
    chk("coalesce_writes", 64'(n_writes - w0), 64'd2);
`endif

    // Reset mid-drain discards pending stores.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1000_0300 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    w0 = n_writes;
    do_reset();
    idle(3, 1'b1);
    chk("post_reset_writes", 64'(n_writes - w0), 64'd0);

    // Randomized traffic over a small word pool to provoke hazards and merges.
    for (int n = 0; n < 400; n++) begin
      r_wr = ($urandom % 10) < 4;
      r_rd = !r_wr && (($urandom % 10) < 3);
      r_wa = 32'h1000_0000 + 32'(($urandom % 6) * 4) + 32'($urandom % 4);
      r_ra = 32'h1000_0000 + 32'(($urandom % 8) * 4) + 32'($urandom % 4);
      cycle(r_wr, r_wa, $urandom, 4'($urandom_range(1, 15)), r_rd, r_ra, ($urandom % 10) < 6);
      if (n == 200) do_reset();
    end

    // Drain what remains, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1, 1'b1);
    idle(1, 1'b1);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer between the CPU data port and data memory. Stores retire from the CPU in one cycle into a small FIFO and drain to data memory when the port is idle. Loads take priority on the shared memory address port. A load that overlaps a pending store stalls the CPU until that store has drained.

## Interface
Parameters:
- DEPTH, 4 — buffer entries; power of two, 2..16.
- ADDR_WIDTH, 32 — byte address width.
- DATA_WIDTH, 32 — word width; byte enables are DATA_WIDTH/8 bits.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserted when 0, released synchronously to clk by the driver.
- cpu_wr_en  in  1  store request this cycle.
- cpu_wr_addr  in  ADDR_WIDTH  store byte address.
- cpu_wr_data  in  DATA_WIDTH  store data, byte lanes aligned to address.
- cpu_wr_be  in  4  store byte enables.
- cpu_rd_en  in  1  load request this cycle.
- cpu_rd_addr  in  ADDR_WIDTH  load byte address.
- sb_stall  out  1  CPU must hold its memory-stage request.
- sb_empty  out  1  no valid entries.
- mem_wr_en  out  1  drain write strobe.
- mem_rd_en  out  1  load forwarded to memory.
- mem_addr  out  ADDR_WIDTH  shared memory address.
- mem_wr_data  out  DATA_WIDTH  drain data.
- mem_wr_be  out  4  drain byte enables.
- mem_ready  in  1  memory accepts the current write this cycle.

## Operation
- Buffer is a circular FIFO with head pointer, tail pointer and count (0..DEPTH).
- Each entry holds a valid bit, word address (addr[ADDR_WIDTH-1:2]), data and be.
- Store accept:
  - Condition: cpu_wr_en and count<DEPTH.
  - Action: write the entry at tail, tail+1 mod DEPTH, count+1.
  - If count==DEPTH: sb_stall=1 and the store is not taken, even when a pop happens in the same cycle. This keeps stall off the mem_ready path.
- Load hazard:
  - Condition: cpu_rd_en and cpu_rd_addr[ADDR_WIDTH-1:2] matches any valid entry, regardless of be.
  - Action: sb_stall=1 and mem_rd_en=0; draining continues.
  - Hazard clears in the cycle after the last matching entry pops.
- Load pass:
  - Condition: cpu_rd_en with no hazard.
  - Action: mem_rd_en=1, mem_addr=cpu_rd_addr, mem_wr_en=0. Drain is blocked this cycle.
- Drain:
  - Condition: count>0, and no load pass this cycle.
  - Action: mem_wr_en=1, mem_addr={head word addr,2'b00}, mem_wr_data/mem_wr_be from head.
  - When mem_ready=1: pop, head+1, count-1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- cpu_wr_en and cpu_rd_en together is illegal. Bench asserts on it; RTL treats it as a store only.
- Stores in the same cycle as a pop at count==DEPTH still stall (rule above).
- Pointer wrap: mod DEPTH via the natural log2(DEPTH)-bit overflow.
- Reset: all valid bits cleared, pointers and count = 0. Pending stores are discarded, including on reset mid-drain.

## Timing
- Reset values: sb_stall=0, sb_empty=1, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0, mem_wr_be=0.
- Store latency: accepted at edge N. Eligible for drain from cycle N+1. Earliest memory write lands at edge N+1.
- Load pass is combinational: mem_rd_en and mem_addr follow the cpu_rd_* inputs in the same cycle. Read data returns through the existing memory path, not through this block.
- sb_stall is combinational from cpu_*_en/addr and registered state only. It never depends on mem_ready.
- sb_empty is registered state (count==0).
- Drain throughput: one entry per cycle while mem_ready=1 and no loads are present.

## Configuration
- DMEM_SB_COALESCE_EN defined:
  - Merge condition: a store whose word address equals the youngest valid entry, where that entry is not the head being presented with mem_ready=1 this cycle.
  - Merge action: enabled bytes are written into that entry and be is OR-ed in. count and tail are unchanged.
  - Coalescing is allowed even when count==DEPTH, in which case no stall is raised.
- DMEM_SB_COALESCE_EN undefined: every accepted store allocates a new entry.

## Structure
- Shared package dmem_sb_pkg: entry struct (valid, word addr, data, be) and the BE_WIDTH constant.
- One sub-module, dmem_sb_match: a DEPTH-wide parallel word-address comparator returning a hit vector. It is used for load hazard detection and for coalescing (youngest-entry select).
- FIFO pointers and drain/load arbitration stay in the top block.

## Test plan
- Reset mid-drain: 3 stores queued, rst=0 for one cycle -> sb_empty=1, no further mem_wr_en, all outputs at reset values.
- Fill to full: with mem_ready=0, 4 stores to 0x1000_0000..0x1000_000C are accepted. A 5th store raises sb_stall=1. Drop mem_ready to 1 -> stall clears the cycle after the first pop, and writes land in order.
- Load hazard: store 0xDEADBEEF to 0x1000_0010 with mem_ready=0. Load from 0x1000_0012 -> sb_stall=1 and mem_rd_en=0. mem_ready=1 -> write drains, next cycle mem_rd_en=1 and stall=0.
- Load priority: 2 entries pending, load to 0x1000_0100 (no match) -> mem_rd_en=1, mem_wr_en=0 that cycle, drain resumes the next cycle.
- Wrap-around: 10 store/drain pairs through DEPTH=4 -> 10 writes with correct addr/data/be order and pointer wrap.
- Coalesce (macro on): sb 0x11 at 0x1000_0020, then sb 0x22 at 0x1000_0021 -> one write, be=4'b0011, data[15:0]=0x2211. Macro off -> two writes.
